// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters/transmitter and uart_tx_arbiter.
// Optional burst-hold input i_lock exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           i_req;
  logic [NUM_REQ*DATA_BITS-1:0] i_data;
  logic                         i_tx_done;
  logic                         o_tx_start;
  logic [DATA_BITS-1:0]         o_tx_data;
  logic [NUM_REQ-1:0]           o_grant;
  logic [NUM_REQ-1:0]           o_ack;
  logic                         o_timeout;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]           i_lock;
`endif

  // Arbiter side
  modport slave (
`ifdef UART_ARB_LOCK_EN
    input  i_lock,
`endif
    input  i_req, i_data, i_tx_done,
    output o_tx_start, o_tx_data, o_grant, o_ack, o_timeout
  );

  // Requester / transmitter side
  modport master (
`ifdef UART_ARB_LOCK_EN
    output i_lock,
`endif
    output i_req, i_data, i_tx_done,
    input  o_tx_start, o_tx_data, o_grant, o_ack, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional feature macro UART_ARB_LOCK_EN: a locked winner may chain frames
// straight from WAIT_DONE back to START without releasing the grant.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 40_000
) (
  input logic              i_Clk,
  input logic              i_Rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 start_q, start_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tout_q, tout_d;
  logic [31:0]          cnt_q, cnt_d;

  logic                 rr_found_c;
  logic [IDX_W-1:0]     rr_idx_c;
  int unsigned          cand_c;
  logic                 hold_c;

  function automatic logic [DATA_BITS-1:0] sel_data(
    input logic [IDX_W-1:0]           idx,
    input logic [NUM_REQ*DATA_BITS-1:0] d
  );
    sel_data = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (idx == IDX_W'(n)) sel_data = d[n*DATA_BITS +: DATA_BITS];
    end
  endfunction

  // Round-robin search starting just after the last winner
  always_comb begin
    rr_found_c = 1'b0;
    rr_idx_c   = '0;
    cand_c     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = (32'(ptr_q) + i) % NUM_REQ;
      if (!rr_found_c && bus.i_req[IDX_W'(cand_c)]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = IDX_W'(cand_c);
      end
    end
  end

  // Burst hold: current winner keeps the transmitter for another frame
  always_comb begin
`ifdef UART_ARB_LOCK_EN
    hold_c = bus.i_lock[win_q] & bus.i_req[win_q];
`else
    hold_c = 1'b0;
`endif
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    tout_d  = tout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rr_found_c) begin
          win_d   = rr_idx_c;
          grant_d = NUM_REQ'(1) << rr_idx_c;
          data_d  = sel_data(rr_idx_c, bus.i_data);
          state_d = START;
        end
      end
      START: begin
        start_d = 1'b1;
        ack_d   = grant_q;
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_tx_done) begin
          if (hold_c) begin
            data_d  = sel_data(win_q, bus.i_data);
            state_d = START;
          end else begin
            ptr_d   = win_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
          tout_d  = 1'b1;
          ptr_d   = win_q;
          grant_d = '0;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_tx_start = start_q;
  assign bus.o_tx_data  = data_q;
  assign bus.o_grant    = grant_q;
  assign bus.o_ack      = ack_q;
  assign bus.o_timeout  = tout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (4 requesters, 8-bit data, timeout 16).
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic i_Clk = 1'b0;
  logic i_Rst;
  always #5 i_Clk = ~i_Clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_BITS(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .TIMEOUT_CYCLES(16)) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int m_ptr  = N - 1;   // reference round-robin pointer (last winner)

  // Reference arbitration rule: first requester after the last winner
  function automatic int exp_winner(input int ptr, input logic [3:0] rq);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr + k) % N;
      if (rq[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] dv, input int w);
    return 8'(dv >> (8 * w));
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Advance until o_tx_start is seen, bounded at 40 cycles
  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.o_tx_start && cyc < 40);
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    bus.i_req = '0;
    bus.i_tx_done = 1'b0;
    tick();
    tick();
    i_Rst = 1'b0;
    m_ptr = N - 1;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    bus.i_req = 4'($urandom);
    bus.i_data = $urandom;
    bus.i_tx_done = 1'b0;
    tick();
    tick();
    checks++; if (bus.o_grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", bus.o_grant); end
    checks++; if (bus.o_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", bus.o_ack); end
    checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.o_tx_start); end
    checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.o_tx_data); end
    checks++; if (bus.o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.o_timeout); end
    i_Rst = 1'b0;
    bus.i_req = '0;
    m_ptr = N - 1;
    tick();
    bus.i_tx_done = 1'b1;   // must be ignored in IDLE
    tick();
    bus.i_tx_done = 1'b0;
    tick();
    checks++; if (bus.o_grant !== 4'b0 || bus.o_tx_start !== 1'b0) begin
      errors++; $display("FAIL idle_hold: grant %b start %b want 0000/0", bus.o_grant, bus.o_tx_start); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.i_data = {24'($urandom), 8'hA5};
    bus.i_req = 4'b0001;
    tick();
    checks++; if (bus.o_tx_start !== 1'b0 || bus.o_grant !== 4'b0001) begin
      errors++; $display("FAIL basic_cycle1: start %b grant %b want 0/0001", bus.o_tx_start, bus.o_grant); end
    bus.i_tx_done = 1'b1;   // must be ignored in START
    tick();
    bus.i_tx_done = 1'b0;
    checks++; if (bus.o_tx_start !== 1'b1) begin errors++; $display("FAIL basic_latency: start got %b want 1", bus.o_tx_start); end
    checks++; if (bus.o_tx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", bus.o_tx_data); end
    checks++; if (bus.o_ack !== 4'b0001) begin errors++; $display("FAIL basic_ack: got %b want 0001", bus.o_ack); end
    bus.i_req = '0;
    tick();
    checks++; if (bus.o_tx_start !== 1'b0 || bus.o_ack !== 4'b0 || bus.o_grant !== 4'b0001) begin
      errors++; $display("FAIL basic_pulse: start %b ack %b grant %b want 0/0000/0001", bus.o_tx_start, bus.o_ack, bus.o_grant); end
    tick();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    checks++; if (bus.o_grant !== 4'b0) begin errors++; $display("FAIL basic_release: grant %b want 0000", bus.o_grant); end
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int cyc;
    int w;
    logic [31:0] dv;
    do_reset();
    bus.i_req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      dv = $urandom;
      bus.i_data = dv;
      w = order[f];
      wait_start(cyc);
      checks++; if (cyc != 2) begin errors++; $display("FAIL rr_latency[%0d]: %0d cycles want 2", f, cyc); end
      checks++; if (bus.o_grant !== 4'(1 << w)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", f, bus.o_grant, 4'(1 << w)); end
      checks++; if (bus.o_ack !== 4'(1 << w)) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", f, bus.o_ack, 4'(1 << w)); end
      checks++; if (bus.o_tx_data !== byte_of(dv, w)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", f, bus.o_tx_data, byte_of(dv, w)); end
      bus.i_data = $urandom;
      tick();
      checks++; if (bus.o_ack !== 4'b0) begin errors++; $display("FAIL rr_ack_pulse[%0d]: got %b want 0000", f, bus.o_ack); end
      repeat (3) tick();
      checks++; if (bus.o_tx_data !== byte_of(dv, w)) begin errors++; $display("FAIL rr_data_stable[%0d]: got %h want %h", f, bus.o_tx_data, byte_of(dv, w)); end
      bus.i_tx_done = 1'b1;
      if (f == 4) bus.i_req = '0;
      tick();
      bus.i_tx_done = 1'b0;
      checks++; if (bus.o_grant !== 4'b0) begin errors++; $display("FAIL rr_idle_gap[%0d]: grant %b want 0000", f, bus.o_grant); end
      m_ptr = w;
    end
    tick();
  endtask

  task automatic test_random();
    int cyc;
    int w;
    logic [3:0] rq;
    logic [31:0] dv;
    rq = 4'($urandom_range(1, 15));
    dv = $urandom;
    bus.i_req = rq;
    bus.i_data = dv;
    for (int f = 0; f < 20; f++) begin
      w = exp_winner(m_ptr, rq);
      wait_start(cyc);
      checks++; if (cyc != 2) begin errors++; $display("FAIL rand_latency[%0d]: %0d cycles want 2", f, cyc); end
      checks++; if (bus.o_grant !== 4'(1 << w) || bus.o_ack !== 4'(1 << w)) begin
        errors++; $display("FAIL rand_grant[%0d]: grant %b ack %b want %b (req %b)", f, bus.o_grant, bus.o_ack, 4'(1 << w), rq); end
      checks++; if (bus.o_tx_data !== byte_of(dv, w)) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", f, bus.o_tx_data, byte_of(dv, w)); end
      tick();
      bus.i_req = 4'($urandom);   // changes during WAIT_DONE have no effect
      bus.i_data = $urandom;
      repeat ($urandom_range(0, 8)) tick();
      checks++; if (bus.o_grant !== 4'(1 << w) || bus.o_tx_data !== byte_of(dv, w)) begin
        errors++; $display("FAIL rand_hold[%0d]: grant %b data %h want %b %h", f, bus.o_grant, bus.o_tx_data, 4'(1 << w), byte_of(dv, w)); end
      rq = (f == 19) ? 4'b0 : 4'($urandom_range(1, 15));
      dv = $urandom;
      bus.i_req = rq;
      bus.i_data = dv;
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
      checks++; if (bus.o_grant !== 4'b0) begin errors++; $display("FAIL rand_release[%0d]: grant %b want 0000", f, bus.o_grant); end
      m_ptr = w;
    end
    tick();
  endtask

  task automatic test_drop();
    int cyc;
    logic [31:0] dv;
    dv = $urandom;
    bus.i_data = dv;
    bus.i_req = 4'b0100;
    wait_start(cyc);
    checks++; if (bus.o_grant !== 4'b0100) begin errors++; $display("FAIL drop_grant: got %b want 0100", bus.o_grant); end
    bus.i_req = 4'b1011;
    bus.i_data = $urandom;
    repeat (4) tick();
    checks++; if (bus.o_tx_data !== byte_of(dv, 2) || bus.o_grant !== 4'b0100) begin
      errors++; $display("FAIL drop_hold: data %h grant %b want %h 0100", bus.o_tx_data, bus.o_grant, byte_of(dv, 2)); end
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    m_ptr = 2;
    wait_start(cyc);
    checks++; if (bus.o_grant !== 4'b1000 || cyc != 2) begin
      errors++; $display("FAIL drop_next: grant %b after %0d cycles want 1000 after 2", bus.o_grant, cyc); end
    bus.i_req = '0;
    tick();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    m_ptr = 3;
  endtask

  task automatic test_timeout();
    int cyc;
    int w;
    logic [3:0] rq;
    logic [31:0] dv;
    bus.i_req = 4'b0010;
    bus.i_data = $urandom;
    wait_start(cyc);
    bus.i_req = '0;
    repeat (15) tick();
    checks++; if (bus.o_timeout !== 1'b0 || bus.o_grant !== 4'b0010) begin
      errors++; $display("FAIL timeout_early: timeout %b grant %b want 0 0010", bus.o_timeout, bus.o_grant); end
    tick();
    checks++; if (bus.o_timeout !== 1'b1 || bus.o_grant !== 4'b0) begin
      errors++; $display("FAIL timeout_fire: timeout %b grant %b want 1 0000", bus.o_timeout, bus.o_grant); end
    m_ptr = 1;
    tick();
    checks++; if (bus.o_ack !== 4'b0 || bus.o_tx_start !== 1'b0) begin
      errors++; $display("FAIL timeout_noack: ack %b start %b want 0000 0", bus.o_ack, bus.o_tx_start); end
    rq = 4'($urandom_range(1, 15));
    dv = $urandom;
    bus.i_req = rq;
    bus.i_data = dv;
    w = exp_winner(m_ptr, rq);
    wait_start(cyc);
    checks++; if (cyc != 2 || bus.o_grant !== 4'(1 << w) || bus.o_tx_data !== byte_of(dv, w)) begin
      errors++; $display("FAIL timeout_rearb: %0d cycles grant %b data %h want 2 %b %h", cyc, bus.o_grant, bus.o_tx_data, 4'(1 << w), byte_of(dv, w)); end
    bus.i_req = '0;
    tick();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    m_ptr = w;
    tick();
    checks++; if (bus.o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", bus.o_timeout); end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bus.i_req = 4'b1001;
    bus.i_data = $urandom;
    wait_start(cyc);
    tick();
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    m_ptr = N - 1;
    checks++; if (bus.o_grant !== 4'b0 || bus.o_ack !== 4'b0 || bus.o_tx_start !== 1'b0 ||
                  bus.o_tx_data !== 8'h00 || bus.o_timeout !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: grant %b ack %b start %b data %h timeout %b want all zero",
                         bus.o_grant, bus.o_ack, bus.o_tx_start, bus.o_tx_data, bus.o_timeout); end
    tick();   // arbitration edge, now in START
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    checks++; if (bus.o_ack !== 4'b0 || bus.o_tx_start !== 1'b0 || bus.o_grant !== 4'b0) begin
      errors++; $display("FAIL startrst_outputs: ack %b start %b grant %b want zero", bus.o_ack, bus.o_tx_start, bus.o_grant); end
    wait_start(cyc);
    checks++; if (cyc != 2 || bus.o_grant !== 4'b0001) begin
      errors++; $display("FAIL midrst_priority: grant %b after %0d cycles want 0001 after 2", bus.o_grant, cyc); end
    bus.i_req = '0;
    tick();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    m_ptr = 0;
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    int cyc;
    logic [31:0] dv;
    bus.i_lock = 4'b0010;
    bus.i_req = 4'b0011;
    dv = $urandom;
    bus.i_data = dv;
    wait_start(cyc);
    checks++; if (bus.o_grant !== 4'(1 << exp_winner(m_ptr, 4'b0011))) begin
      errors++; $display("FAIL lock_first: grant %b want 0010", bus.o_grant); end
    for (int fr = 1; fr < 3; fr++) begin
      tick();
      dv = $urandom;
      bus.i_data = dv;
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
      checks++; if (bus.o_grant !== 4'b0010) begin errors++; $display("FAIL lock_nogap[%0d]: grant %b want 0010", fr, bus.o_grant); end
      tick();
      checks++; if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== byte_of(dv, 1)) begin
        errors++; $display("FAIL lock_frame[%0d]: start %b data %h want 1 %h", fr, bus.o_tx_start, bus.o_tx_data, byte_of(dv, 1)); end
    end
    tick();
    bus.i_lock = '0;
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    checks++; if (bus.o_grant !== 4'b0) begin errors++; $display("FAIL lock_release: grant %b want 0000", bus.o_grant); end
    m_ptr = 1;
    wait_start(cyc);
    checks++; if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL lock_next: grant %b want 0001", bus.o_grant); end
    bus.i_req = '0;
    tick();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask
`endif

  initial begin
    i_Rst = 1'b1;
    bus.i_req = '0;
    bus.i_data = '0;
    bus.i_tx_done = 1'b0;
`ifdef UART_ARB_LOCK_EN
    bus.i_lock = '0;
`endif
    test_reset();
    test_basic();
    test_round_robin();
    test_random();
    test_drop();
    test_timeout();
    test_reset_mid_frame();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter, legal range 2..8.
REQ-002 Parameter DATA_BITS, default 8: width of one UART payload, legal range 5..9.
REQ-003 Parameter TIMEOUT_CYCLES, default 40_000: cycles allowed in WAIT_DONE before abort; must be at least 2.
REQ-004 Port i_Clk, input, 1: sole clock; all logic is on the rising edge.
REQ-005 Port i_Rst, input, 1: reset, synchronous and active-high.
REQ-006 Port i_req, input, NUM_REQ: bit n high means requester n holds a byte to send.
REQ-007 Port i_data, input, NUM_REQ*DATA_BITS: requester n payload at bits [n*DATA_BITS +: DATA_BITS].
REQ-008 Port i_tx_done, input, 1: one-cycle pulse from the transmitter when the stop bit completes.
REQ-009 Port o_tx_start, output, 1: one-cycle pulse that launches a transmitter frame.
REQ-010 Port o_tx_data, output, DATA_BITS: registered payload; stable from o_tx_start until i_tx_done.
REQ-011 Port o_grant, output, NUM_REQ: one-hot owner of the transmitter; all-zero when idle.
REQ-012 Port o_ack, output, NUM_REQ: one-cycle pulse on the winner bit when its byte is consumed.
REQ-013 Port o_timeout, output, 1: sticky flag set by a WAIT_DONE timeout.
REQ-014 Port i_lock, input, NUM_REQ: present only with UART_ARB_LOCK_EN; bit n requests burst hold.

Function
REQ-015 The FSM SHALL have three states: IDLE, START and WAIT_DONE.
REQ-016 IDLE, any i_req bit high: pick the winner by round-robin, searching from ptr+1 with modulo NUM_REQ wrap; register o_grant one-hot; latch that requester's i_data into o_tx_data; go to START.
REQ-017 IDLE, i_req all zero: hold state; o_grant stays zero.
REQ-018 START: o_tx_start=1 and o_ack[winner]=1 for exactly that cycle; clear the timeout counter; go to WAIT_DONE.
REQ-019 Latency: o_tx_start SHALL assert exactly 2 cycles after i_req is first sampled high in IDLE (IDLE edge, then START cycle).
REQ-020 WAIT_DONE, on i_tx_done: set ptr to the winner; clear o_grant; go to IDLE.
REQ-021 Consequence of REQ-020: back-to-back frames from different requesters have at least one IDLE cycle between them.
REQ-022 WAIT_DONE, counter reaches TIMEOUT_CYCLES-1 with no i_tx_done: set o_timeout; set ptr to the winner; clear o_grant; go to IDLE; no o_ack is re-issued.
REQ-023 The counter SHALL be 32 bits and SHALL saturate, never wrap.
REQ-024 i_tx_done SHALL be ignored in IDLE and START.
REQ-025 i_req and i_data SHALL be sampled only at arbitration; a request dropped after grant does not cancel the frame.
REQ-026 i_req changes during WAIT_DONE SHALL have no effect until the next arbitration.
REQ-027 o_grant SHALL never have more than one bit set.
REQ-028 A requester SHALL win at most once per NUM_REQ arbitrations while others are also requesting.

Reset
REQ-029 While i_Rst is high at a clock edge, the block SHALL load: state=IDLE; ptr=NUM_REQ-1 (requester 0 has first priority); o_grant=0; o_ack=0; o_tx_start=0; o_tx_data=0; o_timeout=0; counter=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no o_ack and no o_tx_start on the following cycle.
REQ-031 Reset is the only way to clear o_timeout.

Configuration
REQ-032 Macro UART_ARB_LOCK_EN defined: in WAIT_DONE, if i_tx_done occurs while i_lock[winner] and i_req[winner] are both high, go directly to START with the grant kept, ptr unchanged, and the new i_data latched; the back-to-back frame has no IDLE gap.
REQ-033 Macro UART_ARB_LOCK_EN undefined: no i_lock port; behaviour is exactly REQ-020.

Verification
REQ-034 Reset, then i_req=4'b0001, data0=8'hA5 -> o_tx_start 2 cycles later with o_tx_data=8'hA5, o_grant=4'b0001, o_ack=4'b0001 pulse.
REQ-035 i_req=4'b1111 held, i_tx_done issued 5 cycles after each start -> grant order 0,1,2,3,0; each o_ack is a single-cycle pulse.
REQ-036 Grant to requester 2, then i_req[2] dropped during WAIT_DONE -> o_tx_data unchanged until i_tx_done; next grant goes to the next requester after 2.
REQ-037 TIMEOUT_CYCLES=16, no i_tx_done -> o_timeout=1 after 16 WAIT_DONE cycles; o_grant=0; next request arbitrates normally; o_timeout stays 1 until i_Rst.
REQ-038 i_Rst during WAIT_DONE -> all outputs 0 next cycle; first new grant goes to requester 0 even when i_req=4'b1001.
REQ-039 UART_ARB_LOCK_EN defined, i_lock=4'b0010, i_req=4'b0011 -> requester 1 sends 3 frames back-to-back with no IDLE cycle, then requester 0 wins once i_lock is dropped.
